// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Optional feature macro: FETCH_FAULT_EN (adds a per-entry fetch fault bit).
package fetch_unit_pkg;

    // Default queue depth, also used by the core top when instantiating fetch.
    localparam int unsigned FETCH_DEPTH = 4;

    // One queue slot: the fetch PC, the returned word and its fill state.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
`ifdef FETCH_FAULT_EN
        logic        fault;
`endif
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_RESET = '0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests at pc_in, pairs
// returned words with their PC in a small in-order queue and hands them to
// decode. A flush kills queued entries and turns in-flight fetches into
// discard credits so their late responses are dropped.
// Optional feature macro: FETCH_FAULT_EN (imem_rsp_err in, dec_fault out).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
`ifdef FETCH_FAULT_EN
    input  logic        imem_rsp_err,
    output logic        dec_fault,
`endif
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    fetch_entry_t entries_q [DEPTH];
    fetch_entry_t entries_d [DEPTH];

    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0] discard_cnt_q, discard_cnt_d;

    logic [IW-1:0] alloc_idx;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] rd_idx;
    logic [PW:0]   used;
    logic          credit_ok;
    logic          issue;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          not_empty;
    logic          pop;
    fetch_entry_t  head;

    assign alloc_idx = alloc_ptr_q[IW-1:0];
    assign fill_idx  = fill_ptr_q[IW-1:0];
    assign rd_idx    = rd_ptr_q[IW-1:0];

    // Occupied slots plus responses still owed to a flushed stream; one extra
    // bit keeps the sum exact.
    assign used      = {1'b0, alloc_ptr_q - rd_ptr_q} + {1'b0, discard_cnt_q};
    assign credit_ok = used < (PW+1)'(DEPTH);

    assign imem_req_valid = ~rst & credit_ok & ~flush;
    assign imem_req_addr  = pc_in;
    assign issue          = imem_req_valid & imem_req_ready;
    assign pc_en          = issue;

    assign rsp_drop = imem_rsp_valid & (discard_cnt_q != '0);
    assign rsp_fill = imem_rsp_valid & (discard_cnt_q == '0);

    assign head      = entries_q[rd_idx];
    assign not_empty = rd_ptr_q != alloc_ptr_q;
    assign dec_valid = head.filled & not_empty;
    assign dec_pc    = not_empty ? head.pc    : '0;
    assign dec_instr = not_empty ? head.instr : '0;
    assign pop       = dec_valid & dec_ready;

`ifdef FETCH_FAULT_EN
    assign dec_fault = dec_valid & head.fault;
`endif

    // Next-state for queue storage, pointers and discard credits; flush wins
    // over issue and pop, while a same-cycle response is folded into the
    // discard count instead of being written.
    always_comb begin
        entries_d     = entries_q;
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        discard_cnt_d = discard_cnt_q;

        if (flush) begin
            alloc_ptr_d   = '0;
            fill_ptr_d    = '0;
            rd_ptr_d      = '0;
            discard_cnt_d = (alloc_ptr_q - fill_ptr_q) + discard_cnt_q
                            - PW'(imem_rsp_valid);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
        end else begin
            if (issue) begin
                entries_d[alloc_idx].pc     = pc_in;
                entries_d[alloc_idx].filled = 1'b0;
`ifdef FETCH_FAULT_EN
                entries_d[alloc_idx].fault  = 1'b0;
`endif
                alloc_ptr_d = alloc_ptr_q + 1'b1;
            end

            if (rsp_drop) begin
                discard_cnt_d = discard_cnt_q - 1'b1;
            end else if (rsp_fill) begin
                entries_d[fill_idx].instr  = imem_rsp_data;
                entries_d[fill_idx].filled = 1'b1;
`ifdef FETCH_FAULT_EN
                entries_d[fill_idx].fault  = imem_rsp_err;
`endif
                fill_ptr_d = fill_ptr_q + 1'b1;
            end

            if (pop) begin
                entries_d[rd_idx].filled = 1'b0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            discard_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= ENTRY_RESET;
            end
        end else begin
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            discard_cnt_q <= discard_cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule
